// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_if
// Description : Stage-2 result bundle into writeback plus the register-file
//               write and forwarding bus driven back out of stage 3.
//               Optional macro WB_TOHOST_CSR_EN adds the tohost CSR signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_if #(
    parameter int XLEN = 32
);
    logic            s2_valid;
    logic [4:0]      s2_rd;
    logic            s2_reg_we;
    logic [1:0]      s2_wb_sel;
    logic [XLEN-1:0] s2_alu_out;
    logic [XLEN-1:0] s2_pc;
    logic [2:0]      s2_funct3;
    logic [XLEN-1:0] dmem_rdata;

    logic [4:0]      rd;
    logic [XLEN-1:0] wb_data;
    logic            we;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic [XLEN-1:0] s3_pc;

`ifdef WB_TOHOST_CSR_EN
    logic            s2_csr_we;
    logic [11:0]     s2_csr_addr;
    logic [XLEN-1:0] tohost;

    modport master (
        output s2_valid, s2_rd, s2_reg_we, s2_wb_sel, s2_alu_out, s2_pc,
               s2_funct3, dmem_rdata, s2_csr_we, s2_csr_addr,
        input  rd, wb_data, we, fwd_valid, fwd_rd, fwd_data, s3_pc, tohost
    );
    modport slave (
        input  s2_valid, s2_rd, s2_reg_we, s2_wb_sel, s2_alu_out, s2_pc,
               s2_funct3, dmem_rdata, s2_csr_we, s2_csr_addr,
        output rd, wb_data, we, fwd_valid, fwd_rd, fwd_data, s3_pc, tohost
    );
`else
    modport master (
        output s2_valid, s2_rd, s2_reg_we, s2_wb_sel, s2_alu_out, s2_pc,
               s2_funct3, dmem_rdata,
        input  rd, wb_data, we, fwd_valid, fwd_rd, fwd_data, s3_pc
    );
    modport slave (
        input  s2_valid, s2_rd, s2_reg_we, s2_wb_sel, s2_alu_out, s2_pc,
               s2_funct3, dmem_rdata,
        output rd, wb_data, we, fwd_valid, fwd_rd, fwd_data, s3_pc
    );
`endif
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : RV32 stage-3 writeback: registers the stage-2 bundle, selects
//               ALU / aligned load / PC+4 and drives register-file write and
//               forwarding bus. Optional macro WB_TOHOST_CSR_EN adds tohost.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_2000
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      stall,
    wb_stage_if.slave bus
);
    localparam logic [11:0] c_tohost_addr = 12'h51E;

    logic            r_valid;
    logic [4:0]      r_rd;
    logic            r_reg_we;
    logic [1:0]      r_wb_sel;
    logic [XLEN-1:0] r_alu_out;
    logic [XLEN-1:0] r_pc;
    logic [2:0]      r_funct3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_rd      <= 5'd0;
            r_reg_we  <= 1'b0;
            r_wb_sel  <= 2'd0;
            r_alu_out <= '0;
            r_pc      <= RESET_PC;
            r_funct3  <= 3'd0;
        end else if (!stall) begin
            r_valid   <= bus.s2_valid;
            r_rd      <= bus.s2_rd;
            r_reg_we  <= bus.s2_reg_we;
            r_wb_sel  <= bus.s2_wb_sel;
            r_alu_out <= bus.s2_alu_out;
            r_pc      <= bus.s2_pc;
            r_funct3  <= bus.s2_funct3;
        end
    end

    logic [1:0]      w_offset;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_sel_data;
    logic [XLEN-1:0] w_wb_data;
    logic            w_write;

    assign w_offset = r_alu_out[1:0];

    // Load alignment: halfword picks by offset[1] only, misaligned bit ignored.
    always_comb begin
        w_byte = bus.dmem_rdata[7:0];
        case (w_offset)
            2'd1:    w_byte = bus.dmem_rdata[15:8];
            2'd2:    w_byte = bus.dmem_rdata[23:16];
            2'd3:    w_byte = bus.dmem_rdata[31:24];
            default: w_byte = bus.dmem_rdata[7:0];
        endcase
        w_half = w_offset[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        case (r_wb_sel)
            2'd1:    w_sel_data = w_load;
            2'd2:    w_sel_data = r_pc + {{(XLEN-3){1'b0}}, 3'd4};
            default: w_sel_data = r_alu_out;
        endcase
    end

    assign w_wb_data = r_valid ? w_sel_data : '0;
    assign w_write   = r_valid & r_reg_we & (r_rd != 5'd0);

    // Forwarding stays live during stall so stage 1/2 can bypass the held value.
    assign bus.rd        = r_rd;
    assign bus.wb_data   = w_wb_data;
    assign bus.we        = w_write & ~stall;
    assign bus.fwd_valid = w_write;
    assign bus.fwd_rd    = r_rd;
    assign bus.fwd_data  = w_wb_data;
    assign bus.s3_pc     = r_pc;

`ifdef WB_TOHOST_CSR_EN
    logic            r_csr_we;
    logic [11:0]     r_csr_addr;
    logic [XLEN-1:0] r_tohost;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csr_we   <= 1'b0;
            r_csr_addr <= 12'd0;
            r_tohost   <= '0;
        end else begin
            if (!stall) begin
                r_csr_we   <= bus.s2_csr_we;
                r_csr_addr <= bus.s2_csr_addr;
            end
            if (r_valid && r_csr_we && (r_csr_addr == c_tohost_addr) && !stall) begin
                r_tohost <= r_alu_out;
            end
        end
    end

    assign bus.tohost = r_tohost;
`endif
endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Scoreboard bench for wb_stage: directed and random stimulus,
//               expected outputs queued per cycle by a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
    localparam logic [31:0] c_reset_pc = 32'h0000_2000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;

    wb_stage_if #(.XLEN(32)) bus ();

    wb_stage #(.XLEN(32), .RESET_PC(c_reset_pc)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [2:0]  f3;
        logic        has_want;
        logic [31:0] want;
    } ins_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fwd;
        logic [31:0] pc;
        logic        has_want;
        logic [31:0] want;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    ins_t s2_m;
    ins_t cur;
    logic rst_app = 1'b1;
    logic stl_app = 1'b0;

    function automatic ins_t mk(logic v, logic [4:0] rd, logic we, logic [1:0] sel,
                                logic [31:0] alu, logic [31:0] pc, logic [2:0] f3,
                                logic hw, logic [31:0] want);
        ins_t i;
        i.v = v; i.rd = rd; i.we = we; i.sel = sel; i.alu = alu; i.pc = pc;
        i.f3 = f3; i.has_want = hw; i.want = want;
        return i;
    endfunction

    function automatic logic [31:0] load_value(logic [2:0] f3, logic [1:0] off, logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * off)) % 256;
        h = (word >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic exp_t model_out(ins_t c, logic stl, logic [31:0] dm);
        exp_t e;
        logic wr;
        if (!c.v)             e.data = 32'd0;
        else if (c.sel == 1)  e.data = load_value(c.f3, c.alu[1:0], dm);
        else if (c.sel == 2)  e.data = c.pc + 32'd4;
        else                  e.data = c.alu;
        wr         = c.v && c.we && (c.rd != 5'd0);
        e.we       = wr && !stl;
        e.fwd      = wr;
        e.rd       = c.rd;
        e.pc       = c.pc;
        e.has_want = c.has_want && c.v;
        e.want     = c.want;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    // One clock of stimulus: advance the model past the edge, apply new inputs,
    // queue the outputs expected for the cycle that follows.
    task automatic step(input logic rst_i, input logic stl_i, input ins_t nxt,
                        input logic [31:0] dm_i);
        logic hold;
        @(posedge clk);
        #1;
        hold = stl_app && !rst_app;
        if (rst_app)       cur = mk(0, 0, 0, 0, 0, c_reset_pc, 0, 0, 0);
        else if (!stl_app) cur = s2_m;
        reset          = rst_i;
        stall          = stl_i;
        bus.s2_valid   = nxt.v;
        bus.s2_rd      = nxt.rd;
        bus.s2_reg_we  = nxt.we;
        bus.s2_wb_sel  = nxt.sel;
        bus.s2_alu_out = nxt.alu;
        bus.s2_pc      = nxt.pc;
        bus.s2_funct3  = nxt.f3;
        s2_m    = nxt;
        rst_app = rst_i;
        stl_app = stl_i;
        if (!hold) bus.dmem_rdata = dm_i;
        exp_q.push_back(model_out(cur, stl_i, bus.dmem_rdata));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("we",        {31'd0, bus.we},        {31'd0, mon_e.we});
            chk("rd",        {27'd0, bus.rd},        {27'd0, mon_e.rd});
            chk("wb_data",   bus.wb_data,            mon_e.data);
            chk("fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, mon_e.fwd});
            chk("fwd_rd",    {27'd0, bus.fwd_rd},    {27'd0, mon_e.rd});
            chk("fwd_data",  bus.fwd_data,           mon_e.data);
            chk("s3_pc",     bus.s3_pc,              mon_e.pc);
            if (mon_e.has_want) chk("directed_data", bus.wb_data, mon_e.want);
        end
    end

    localparam logic [31:0] c_dm = 32'h80F1_7F01;

    initial begin
        bus.s2_valid   = 1'b1;
        bus.s2_rd      = 5'd3;
        bus.s2_reg_we  = 1'b1;
        bus.s2_wb_sel  = 2'd0;
        bus.s2_alu_out = 32'h1234;
        bus.s2_pc      = 32'd0;
        bus.s2_funct3  = 3'd0;
        bus.dmem_rdata = 32'd0;
`ifdef WB_TOHOST_CSR_EN
        bus.s2_csr_we   = 1'b0;
        bus.s2_csr_addr = 12'd0;
`endif
        s2_m = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cur  = s2_m;

        // Reset held two cycles with a valid instruction on the inputs
        step(1, 0, mk(1, 3, 1, 0, 32'h1234, 32'h0, 0, 0, 0), 32'd0);
        step(1, 0, mk(1, 3, 1, 0, 32'h1234, 32'h0, 0, 0, 0), 32'd0);
        step(0, 0, mk(1, 5, 1, 0, 32'hDEAD_BEEF, 32'h100, 0, 1, 32'hDEAD_BEEF), 32'd0);
        // Loads; dmem data for each applies to the instruction now in stage 3
        step(0, 0, mk(1, 10, 1, 1, 32'h1000, 32'h104, 3'b000, 1, 32'h0000_0001), 32'd0);
        step(0, 0, mk(1, 10, 1, 1, 32'h1003, 32'h108, 3'b000, 1, 32'hFFFF_FF80), c_dm);
        step(0, 0, mk(1, 11, 1, 1, 32'h1003, 32'h10C, 3'b100, 1, 32'h0000_0080), c_dm);
        step(0, 0, mk(1, 12, 1, 1, 32'h1002, 32'h110, 3'b001, 1, 32'hFFFF_80F1), c_dm);
        step(0, 0, mk(1, 13, 1, 1, 32'h1001, 32'h114, 3'b101, 1, 32'h0000_7F01), c_dm);
        step(0, 0, mk(1, 14, 1, 1, 32'h1002, 32'h118, 3'b010, 1, 32'h80F1_7F01), c_dm);
        // JAL link values, including wrap past the top of the address space
        step(0, 0, mk(1, 1, 1, 2, 32'h0, 32'hFFFF_FFFC, 0, 1, 32'h0000_0000), c_dm);
        step(0, 0, mk(1, 1, 1, 2, 32'h0, 32'h0000_2000, 0, 1, 32'h0000_2004), c_dm);
        // Stall holds rd=7 for three cycles, then a single write
        step(0, 0, mk(1, 7, 1, 0, 32'h77, 32'h200, 0, 1, 32'h77), c_dm);
        step(0, 1, mk(1, 9, 1, 0, 32'h99, 32'h204, 0, 1, 32'h99), 32'd0);
        step(0, 1, mk(1, 9, 1, 0, 32'h99, 32'h204, 0, 1, 32'h99), 32'd0);
        step(0, 1, mk(1, 9, 1, 0, 32'h99, 32'h204, 0, 1, 32'h99), 32'd0);
        step(0, 0, mk(1, 0, 1, 0, 32'h55, 32'h208, 0, 1, 32'h55), 32'd0);
        step(0, 0, mk(1, 0, 1, 0, 32'h55, 32'h208, 0, 1, 32'h55), 32'd0);
        // Reset arriving during a stall discards the pending instruction
        step(0, 0, mk(1, 4, 1, 0, 32'h44, 32'h300, 0, 0, 0), 32'd0);
        step(1, 1, mk(1, 6, 1, 0, 32'h66, 32'h304, 0, 0, 0), 32'd0);
        step(0, 0, mk(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 40) == 0, ($urandom % 4) == 0,
                 mk($urandom % 2, $urandom % 32, $urandom % 2, $urandom % 4,
                    $urandom, $urandom, $urandom % 8, 0, 0),
                 $urandom);
        end
        step(0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 32'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Stage-3 writeback unit of the 3-stage RV32 pipeline. It is the write-side producer for the register file.
- Registers the stage-2 result bundle and selects the writeback source (ALU, data-memory load, or PC+4).
- Aligns and sign/zero-extends load data, then drives rd/wb_data/we into the register file.
- Mirrors the same write as a forwarding bus back to stages 1/2.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_2000, reset value of the registered PC (debug visibility only).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  global pipeline stall; holds stage-3 state and suppresses writes
- s2_valid  in  1  stage-2 bundle holds a real instruction
- s2_rd  in  5  destination register index
- s2_reg_we  in  1  instruction writes a register
- s2_wb_sel  in  2  source select: 0=ALU, 1=MEM, 2=PC+4, 3=reserved (treated as ALU)
- s2_alu_out  in  XLEN  ALU result; also the load address
- s2_pc  in  XLEN  instruction PC
- s2_funct3  in  3  load width/sign code
- dmem_rdata  in  XLEN  synchronous dmem read data, valid in the cycle after the stage-2 request
- rd  out  5  register file write index
- wb_data  out  XLEN  register file write data
- we  out  1  register file write enable
- fwd_valid  out  1  forwarding bus valid
- fwd_rd  out  5  forwarding destination index
- fwd_data  out  XLEN  forwarding data (equals wb_data)
- s3_pc  out  XLEN  registered PC of the instruction in stage 3

Behaviour:
- Stage-3 register: valid, rd, reg_we, wb_sel, alu_out, pc, funct3.
  - Loaded from the s2_* inputs on a rising edge when stall=0.
  - Holds its value when stall=1.
- Reset (sync, dominates stall): valid=0, rd=0, reg_we=0, wb_sel=0, alu_out=0, funct3=0, pc=RESET_PC.
  - Outputs in the following cycle: we=0, rd=0, wb_data=0, fwd_valid=0, s3_pc=RESET_PC.
- Latency: an instruction sampled at edge N drives rd/wb_data/we during cycle N→N+1. The register file commits it at edge N+1.
- Write enable: we = valid & reg_we & (rd!=0) & ~stall.
- Forwarding: fwd_valid = valid & reg_we & (rd!=0), and is independent of stall. fwd_rd=rd, fwd_data=wb_data, all combinational.
- wb_data while valid=0: forced to 0.
- Source select:
  - wb_sel 0 or 3: alu_out.
  - wb_sel 1: load result.
  - wb_sel 2: pc+4, modulo 2^32 (wraps at 0xFFFF_FFFC→0).
- Load result uses offset = alu_out[1:0] and operates on dmem_rdata:
  - funct3 000 (LB): byte at offset, sign-extended.
  - 100 (LBU): byte at offset, zero-extended.
  - 001 (LH): halfword at offset[1], sign-extended; offset[0] is ignored.
  - 101 (LHU): halfword at offset[1], zero-extended.
  - 010 (LW), 011, 110, 111: full word; offset is ignored.
- Stall: dmem_rdata must be held stable by the memory interface while stall=1. The block does not capture it.
- Reset mid-stall: reset wins and the pending instruction is discarded without writing.
- rd=0 with reg_we=1: no write and no forward, but wb_data still reflects the selected value.

Optional Feature:
- Macro: WB_TOHOST_CSR_EN.
- When defined:
  - Adds inputs s2_csr_we (1) and s2_csr_addr (12), carried in the stage-3 register.
  - Adds output tohost (XLEN), reset to 0.
  - At a rising edge with valid & csr_we & (csr_addr==12'h51E) & ~stall, tohost <= alu_out.
  - Writes to any other CSR address are ignored.
- When undefined: the ports and register are absent. Behaviour is otherwise identical.

Test Plan:
- Reset held 2 cycles with s2_valid=1 → we=0, rd=0, wb_data=0, fwd_valid=0 during and one cycle after reset release.
- ALU op: s2_rd=5, wb_sel=0, alu_out=0xDEADBEEF → next cycle we=1, rd=5, wb_data=0xDEADBEEF, fwd_valid=1, fwd_data=0xDEADBEEF.
- Loads with dmem_rdata=0x80F17F01:
  - LB off0 → 0x00000001.
  - LB off3 → 0xFFFFFF80.
  - LBU off3 → 0x00000080.
  - LH off2 → 0xFFFF80F1.
  - LHU off1 → 0x00007F01.
  - LW off2 → 0x80F17F01.
- JAL writeback: wb_sel=2, pc=0xFFFFFFFC, rd=1 → wb_data=0x00000000. With pc=0x2000 → wb_data=0x2004.
- Stall: ALU op to rd=7, stall=1 for 3 cycles → we=0 each cycle, fwd_valid=1, stage holds. Stall released → exactly one write of the held value. rd=0 with reg_we=1 → we=0, fwd_valid=0.
- WB_TOHOST_CSR_EN: csr_we=1, addr=0x51E, alu_out=1 → tohost=1 one edge later. addr=0x340 → tohost unchanged. Stall=1 → no update.
